systolic_matmul_driver: RTL and testbench

- Initiator-side front end for the systolic matrix multiplier.
- Collects two SIZE x SIZE operand matrices from a narrow element stream (valid/ready), A first and then B, each in row-major order.
- Launches the multiplier with a single-cycle valid pulse and waits for its ready indication.
- Captures the product matrix and streams it out row-major as WIDTH-bit elements with valid/ready and a last flag.

---
 rtl/systolic_pkg.sv | 28 ++
 rtl/systolic_matmul_driver_matrix_serializer.sv | 65 ++++++
 rtl/systolic_matmul_driver.sv | 140 ++++++++++++++
 tb/tb_systolic_matmul_driver.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default configuration for the systolic matrix multiplier driver.
package systolic_pkg;

    localparam int unsigned SIZE_DEF    = 3;
    localparam int unsigned WIDTHX_DEF  = 4;
    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Counter width helper; never returns zero so single-element configs stay legal
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ELEMS = SIZE_DEF * SIZE_DEF;
    localparam int unsigned IDX_W = clog2_min1(ELEMS);
    localparam int unsigned TMR_W = clog2_min1(TIMEOUT_DEF + 1);

    typedef logic [2:0] state_t;

    localparam state_t S_LOAD_A   = 3'd0;
    localparam state_t S_LOAD_B   = 3'd1;
    localparam state_t S_LAUNCH   = 3'd2;
    localparam state_t S_WAIT_RDY = 3'd3;
    localparam state_t S_SETTLE   = 3'd4;
    localparam state_t S_CAPTURE  = 3'd5;
    localparam state_t S_DRAIN    = 3'd6;

endpackage

// File: rtl/systolic_matmul_driver_matrix_serializer.sv
// Result register bank streamed out row-major over valid/ready with a last flag.
module matrix_serializer
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ELEMS_P = ELEMS,
    parameter int unsigned IDX_WP  = IDX_W
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            load,
    input  logic [ELEMS_P-1:0][WIDTH-1:0]   data,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_last,
    output logic                            done_c
);

    localparam logic [IDX_WP-1:0] IDX_LAST = IDX_WP'(ELEMS_P - 1);

    logic [ELEMS_P-1:0][WIDTH-1:0] res_q;
    logic [IDX_WP-1:0]             idx_q;
    logic [IDX_WP-1:0]             idx_nxt_c;
    logic                          valid_q;
    logic                          last_q;
    logic [WIDTH-1:0]              data_q;
    logic                          fire_c;

    assign fire_c    = valid_q && out_ready;
    assign done_c    = fire_c && (idx_q == IDX_LAST);
    assign idx_nxt_c = idx_q + IDX_WP'(1);

    // Output element and flags only move on a handshake, so backpressure holds them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            res_q   <= data;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= data[0];
            last_q  <= (ELEMS_P == 1);
        end else if (fire_c) begin
            if (idx_q == IDX_LAST) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                idx_q   <= idx_nxt_c;
                data_q  <= res_q[idx_nxt_c];
                last_q  <= (idx_nxt_c == IDX_LAST);
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/systolic_matmul_driver.sv
// Initiator front end: loads A then B from an element stream, launches the multiplier,
// waits (bounded) for completion and streams the captured product out row-major.
module systolic_matmul_driver
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SIZE    = SIZE_DEF,
    parameter int unsigned WIDTHx  = WIDTHX_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTHx-1:0]                    in_data,
    output logic                                 mm_valid_o,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] mm_a_o,
    output logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] mm_b_o,
    input  logic                                 mm_ready_i,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mm_product_i,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    output logic                                 out_last,
    output logic                                 err_o
);

    localparam int unsigned N_EL = SIZE * SIZE;
    localparam int unsigned IW   = clog2_min1(N_EL);
    localparam int unsigned TW   = clog2_min1(TIMEOUT + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(N_EL - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    state_t                     state_q;
    state_t                     state_d;
    logic [IW-1:0]              idx_q;
    logic [TW-1:0]              tmr_q;
    logic [N_EL-1:0][WIDTHx-1:0] a_q;
    logic [N_EL-1:0][WIDTHx-1:0] b_q;
    logic                       in_ready_q;
    logic                       mm_valid_q;
    logic                       err_q;

    logic                       accept_c;
    logic                       idx_last_c;
    logic                       timeout_c;
    logic                       capture_c;
    logic                       drain_done_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; mm_ready_i is only looked at while waiting and beats the timeout
    always_comb begin
        state_d    = state_q;
        timeout_c  = 1'b0;
        accept_c   = in_ready_q && in_valid;
        idx_last_c = (idx_q == IDX_LAST);
        capture_c  = (state_q == S_CAPTURE);
        case (state_q)
            S_LOAD_A:   if (accept_c && idx_last_c) state_d = S_LOAD_B;
            S_LOAD_B:   if (accept_c && idx_last_c) state_d = S_LAUNCH;
            S_LAUNCH:   state_d = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (mm_ready_i) begin
                    state_d = S_SETTLE;
                end else if (tmr_q == TMR_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = S_LOAD_A;
                end
            end
            S_SETTLE:   state_d = S_CAPTURE;
            S_CAPTURE:  state_d = S_DRAIN;
            S_DRAIN:    if (drain_done_c) state_d = S_LOAD_A;
            default:    state_d = S_LOAD_A;
        endcase
    end

    // Load-side datapath, launch pulse, timer and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            tmr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b0;
            mm_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_ready_q <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
            mm_valid_q <= (state_d == S_LAUNCH);

            if (state_d != state_q) begin
                idx_q <= '0;
            end else if (accept_c) begin
                idx_q <= idx_q + IW'(1);
            end

            if (accept_c && (state_q == S_LOAD_A)) a_q[idx_q] <= in_data;
            if (accept_c && (state_q == S_LOAD_B)) b_q[idx_q] <= in_data;

            if (state_q == S_LAUNCH) begin
                tmr_q <= '0;
            end else if (state_q == S_WAIT_RDY) begin
                tmr_q <= tmr_q + TW'(1);
            end

            if (timeout_c) err_q <= 1'b1;
        end
    end

    matrix_serializer #(
        .WIDTH   (WIDTH),
        .ELEMS_P (N_EL),
        .IDX_WP  (IW)
    ) u_serializer (
        .clock     (clock),
        .reset     (reset),
        .load      (capture_c),
        .data      (mm_product_i),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done_c    (drain_done_c)
    );

    assign in_ready   = in_ready_q;
    assign mm_valid_o = mm_valid_q;
    assign mm_a_o     = a_q;
    assign mm_b_o     = b_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_systolic_matmul_driver.sv
// Scoreboard bench for systolic_matmul_driver with a behavioural multiplier model.
module tb_systolic_matmul_driver;

    localparam int SZ  = 3;
    localparam int WX  = 4;
    localparam int W   = 16;
    localparam int NEL = SZ * SZ;

    logic                          clock = 1'b0;
    logic                          reset;
    logic                          in_valid;
    logic                          in_ready;
    logic [WX-1:0]                 in_data;
    logic                          mm_valid_o;
    logic [SZ-1:0][SZ-1:0][WX-1:0] mm_a_o;
    logic [SZ-1:0][SZ-1:0][WX-1:0] mm_b_o;
    logic                          mm_ready_i;
    logic [SZ-1:0][SZ-1:0][W-1:0]  mm_product_i;
    logic                          out_valid;
    logic                          out_ready;
    logic [W-1:0]                  out_data;
    logic                          out_last;
    logic                          err_o;

    systolic_matmul_driver #(
        .WIDTH(W), .SIZE(SZ), .WIDTHx(WX), .TIMEOUT(64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mm_valid_o   (mm_valid_o),
        .mm_a_o       (mm_a_o),
        .mm_b_o       (mm_b_o),
        .mm_ready_i   (mm_ready_i),
        .mm_product_i (mm_product_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_o        (err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [WX-1:0]                 cur_a [NEL];
    logic [WX-1:0]                 cur_b [NEL];
    logic [SZ-1:0][SZ-1:0][WX-1:0] exp_mm_a;
    logic [SZ-1:0][SZ-1:0][WX-1:0] exp_mm_b;
    logic [SZ-1:0][SZ-1:0][W-1:0]  mdl_p;
    int                            mdl_s;

    int model_delay    = 5;
    int model_hold     = 2;
    bit model_no_ready = 1'b0;

    int cyc = 0, launch_cyc = 0, err_cyc = 0, hs_cnt = 0, out_seen = 0;
    bit err_in_ready = 1'b0;
    bit prev_mmv = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;

    int stall_at = -1, stall_len = 0, stall_cnt = 0;
    bit rand_bp = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Multiplier model: computes A*B from the launched operands and answers after model_delay cycles
    initial begin
        mm_ready_i   = 1'b0;
        mm_product_i = '0;
        forever begin
            @(negedge clock);
            if (!reset && mm_valid_o) begin
                for (int i = 0; i < SZ; i++) begin
                    for (int j = 0; j < SZ; j++) begin
                        mdl_s = 0;
                        for (int k = 0; k < SZ; k++)
                            mdl_s += int'(mm_a_o[i][k]) * int'(mm_b_o[k][j]);
                        mdl_p[i][j] = W'(mdl_s);
                    end
                end
                if (!model_no_ready) begin
                    repeat (model_delay) @(posedge clock);
                    #1;
                    mm_product_i = mdl_p;
                    mm_ready_i   = 1'b1;
                    repeat (model_hold) @(posedge clock);
                    #1;
                    mm_ready_i   = 1'b0;
                end
            end
        end
    end

    // Result consumer: optional scripted stall after a given handshake count, or random backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (stall_at >= 0 && hs_cnt == stall_at) begin
                out_ready = 1'b0;
                stall_cnt = stall_len - 1;
                stall_at  = -1;
            end else begin
                out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks protocol rules
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                prev_valid = 1'b0;
                prev_mmv   = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (mm_valid_o) begin
                    chk("mm_valid_single_pulse", 64'(prev_mmv), 64'd0);
                    chk("mm_a_at_launch", 64'(mm_a_o), 64'(exp_mm_a));
                    chk("mm_b_at_launch", 64'(mm_b_o), 64'(exp_mm_b));
                    launch_cyc = cyc;
                end
                if (err_o && !prev_err) begin
                    err_cyc      = cyc;
                    err_in_ready = in_ready;
                end
                if (prev_valid && !prev_ready) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data_last", 64'({out_last, out_data}), 64'({prev_last, prev_data}));
                end
                if (out_valid) chk("no_load_drain_overlap", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    out_seen++;
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d last %0b, expected no output", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_elem_last_data", 64'({out_last, out_data}), 64'({e.last, e.data}));
                    end
                end
                prev_mmv   = mm_valid_o;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                prev_err   = err_o;
            end
        end
    end

    task automatic send_elem(input logic [WX-1:0] d);
        int guard = 0;
        repeat ($urandom_range(0, 1)) begin
            in_valid = 1'b0;
            in_data  = WX'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (guard >= 200) chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = WX'($urandom);
    endtask

    // Queue the reference product (row-major, last on element NEL-1) and stream A then B
    task automatic load_txn(input bit timeout_mode);
        exp_t e;
        hs_cnt         = 0;
        out_seen       = 0;
        model_no_ready = timeout_mode;
        for (int i = 0; i < SZ; i++) begin
            for (int j = 0; j < SZ; j++) begin
                exp_mm_a[i][j] = cur_a[i*SZ+j];
                exp_mm_b[i][j] = cur_b[i*SZ+j];
            end
        end
        if (!timeout_mode) begin
            for (int i = 0; i < SZ; i++) begin
                for (int j = 0; j < SZ; j++) begin
                    int s = 0;
                    for (int k = 0; k < SZ; k++) s += int'(cur_a[i*SZ+k]) * int'(cur_b[k*SZ+j]);
                    e.data = W'(s);
                    e.last = (i == SZ - 1) && (j == SZ - 1);
                    exp_q.push_back(e);
                end
            end
        end
        for (int n = 0; n < NEL; n++) send_elem(cur_a[n]);
        for (int n = 0; n < NEL; n++) send_elem(cur_b[n]);
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        guard = 0;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk({name, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic set_random();
        for (int n = 0; n < NEL; n++) begin
            cur_a[n] = WX'($urandom);
            cur_b[n] = WX'($urandom);
        end
    endtask

    task automatic set_identity_seq();
        for (int n = 0; n < NEL; n++) begin
            cur_a[n] = (n / SZ == n % SZ) ? WX'(1) : WX'(0);
            cur_b[n] = WX'(n + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_mm_valid", 64'(mm_valid_o), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_last", 64'(out_last), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_mm_a", 64'(mm_a_o), 64'd0);
        #10;
        reset = 1'b0;
        @(posedge clock);
        #1;

        set_identity_seq();
        model_delay = 5;
        load_txn(1'b0);
        wait_drain("identity_seq");

        for (int n = 0; n < NEL; n++) begin cur_a[n] = WX'(2); cur_b[n] = WX'(3); end
        model_delay = 1;
        load_txn(1'b0);
        wait_drain("twos_threes");

        for (int n = 0; n < NEL; n++) begin cur_a[n] = WX'(15); cur_b[n] = WX'(15); end
        model_delay = 9;
        load_txn(1'b0);
        wait_drain("all_max");

        set_identity_seq();
        model_delay = 3;
        load_txn(1'b0);
        stall_len = 5;
        stall_at  = 3;
        wait_drain("stall_after_third");
        chk("err_still_clear", 64'(err_o), 64'd0);

        // Ready arriving on the last allowed wait cycle must beat the timeout
        set_random();
        model_delay = 64;
        load_txn(1'b0);
        wait_drain("ready_at_timeout_edge");
        chk("err_clear_ready_wins", 64'(err_o), 64'd0);

        set_random();
        load_txn(1'b1);
        guard = 0;
        while (err_o !== 1'b1 && guard < 300) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk("timeout_err_set", 64'(err_o), 64'd1);
        @(negedge clock);
        #1;
        // LAUNCH cycle, then 64 waiting cycles; err is visible the cycle after the last wait
        chk("timeout_err_latency", 64'(err_cyc - launch_cyc), 64'd65);
        chk("timeout_in_ready_back", 64'(err_in_ready), 64'd1);
        repeat (10) @(posedge clock);
        #1;
        chk("timeout_no_output", 64'(out_seen), 64'd0);

        set_random();
        model_delay = $urandom_range(1, 20);
        load_txn(1'b0);
        wait_drain("after_timeout");
        chk("err_sticky", 64'(err_o), 64'd1);

        rand_bp = 1'b1;
        for (int t = 0; t < 3; t++) begin
            set_random();
            model_delay = $urandom_range(1, 20);
            model_hold  = $urandom_range(1, 3);
            load_txn(1'b0);
            wait_drain("random_bp");
        end
        rand_bp = 1'b0;

        // Abandon a transaction mid-drain with an asynchronous reset
        set_random();
        model_delay = 4;
        load_txn(1'b0);
        guard = 0;
        while (hs_cnt < 3 && guard < 500) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk("reached_third_output", 64'(hs_cnt), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        chk("async_rst_out_last", 64'(out_last), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        chk("async_rst_err", 64'(err_o), 64'd0);
        chk("async_rst_mm_b", 64'(mm_b_o), 64'd0);
        exp_q.delete();
        #14;
        reset = 1'b0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(posedge clock);
            #1;
            guard++;
        end
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        set_random();
        model_delay = $urandom_range(1, 20);
        load_txn(1'b0);
        wait_drain("post_reset_txn");
        chk("post_reset_err_clear", 64'(err_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
